mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the RV32I multi-cycle core and the 1024x32 word-addressed BRAM Memory block. Accepts one byte-addressed load or store request at a time, drives the Memory's active-low read/write strobes, performs byte/halfword lane selection with sign or zero extension on loads, and uses read-modify-write for sub-word stores. Flags misaligned or illegal accesses without touching memory.

## Interface
- WORDS, 10: Memory address width in words (2^WORDS words).
- DATA_WIDTH, 32: data width; only 32 is supported.
- clk_i  in  1  clock; all state on posedge.
- reset_ni  in  1  asynchronous, active-low reset.
- req_i  in  1  request strobe; sampled only while ready_o=1.
- we_i  in  1  1=store, 0=load.
- funct3_i  in  3  RV32I funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data; the low byte or halfword is used for sb/sh.
- ready_o  out  1  high in IDLE.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result; held until the next load completes.
- err_o  out  1  misaligned/illegal flag; valid with done_o.
- mem_addr_o  out  WORDS  word address, addr[WORDS+1:2].
- mem_data_o  out  32  write data to Memory.
- mem_wr_no  out  1  write enable, active low.
- mem_rd_no  out  1  read enable, active low.
- mem_data_i  in  32  Memory read data.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, req_i=1: register we_i, funct3_i, addr_i, wdata_i; later input changes are ignored. Then branch:
  - Error (misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0; or illegal funct3): go to DONE with err set. No strobe is asserted.
  - Load, or sb/sh: go to RD.
  - sw: go to WR.
- RD: mem_rd_no=0. At the end of RD, capture mem_data_i.
  - Load: compute rdata_o, go to DONE.
  - sb/sh: merge the store lane into the captured word, go to WR.
- WR: mem_wr_no=0, mem_data_o = merged word (sb/sh) or wdata (sw). Go to DONE.
- DONE: done_o=1, err_o = err. Go to IDLE.
- Lanes are little-endian: byte lane = addr[1:0] (lane 0 = bits 7:0); half lane = addr[1].
- Extension: lb/lh sign-extend; lbu/lhu zero-extend.
- Address bits above WORDS+1 are ignored, so addresses wrap modulo 2^(WORDS+2) bytes.
- rdata_o changes only on a successful load. Stores and errors leave it unchanged.
- mem_rd_no and mem_wr_no are never low in the same cycle.

## Timing
- Reset values: ready_o=1, done_o=0, err_o=0, rdata_o=0, mem_addr_o=0, mem_data_o=0, mem_wr_no=1, mem_rd_no=1, state=IDLE.
- Reset asserted mid-operation: immediately return to IDLE and deassert both strobes asynchronously. No partial write is issued after reset.
- All memory outputs are registered and change only on posedge. Memory samples on negedge, which gives a half-cycle setup.
- Read data: Memory registers it on the negedge inside RD; it is stable by the posedge that ends RD.
- Latency, counted from the accepting edge k to done_o high:
  - load: cycle k+2 (IDLE→RD→DONE).
  - sb/sh: cycle k+3 (RD→WR→DONE).
  - sw: cycle k+2 (WR→DONE).
  - error: cycle k+1.
- Back-to-back: after DONE, ready_o=1 in the next cycle. A req_i held high is accepted at that cycle's edge.
- req_i while not ready: ignored, not queued.

## Configuration
- SUBWORD_EN defined: full lb/lh/lbu/lhu/sb/sh support, including read-modify-write.
- SUBWORD_EN undefined:
  - Only lw/sw are legal; every other funct3 sets err_o with no memory access.
  - Lane/extension logic and the RD→WR store path are removed. RD is used only for loads.

## Test plan
- Preload word 10 = 0x55AA3312. Loads:
  - lb @0x2B → 0x00000055.
  - lb @0x2A → 0xFFFFFFAA.
  - lbu @0x2A → 0x000000AA.
  - lhu @0x28 → 0x00003312.
  - Each: done_o exactly 2 cycles after acceptance; exactly one mem_rd_no low cycle.
- sb @0x29, wdata 0x123456EE → word 10 = 0x55AAEE12.
  - One RD cycle then one WR cycle; done_o at k+3.
  - Follow-up lw @0x28 returns 0x55AAEE12.
- sh @0x2A, wdata 0x0000BEEF → 0xBEEFxxxx; sw @0x3FFC, data 0x00000050 → word 1023 = 0x00000050.
  - For the sw: no mem_rd_no pulse; done_o at k+2.
- lw @0x2A, lh @0x29, funct3 011 → err_o=1 with done_o at k+1.
  - Strobes stay high; rdata_o unchanged.
- Address wrap: lw @0x1028 reads word 10.
- Reset mid-op: assert reset_ni low during the WR of an sb.
  - Strobes go high immediately; the memory word is unchanged (no write edge occurs).
  - After release, ready_o=1 and outputs are at their reset values.
- Build without SUBWORD_EN: lb → err_o=1, no memory access; lw and sw unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed BRAM: one request at a time, RMW for sub-word stores.
// Optional macro SUBWORD_EN enables lb/lh/lbu/lhu/sb/sh; without it only lw/sw are legal.
module mem_access_unit #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wr_no,
  output logic                  mem_rd_no,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                  state_q, state_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [WORDS-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    mem_wr_n_q, mem_wr_n_d;
  logic                    mem_rd_n_q, mem_rd_n_d;
  logic                    req_err;
  logic [DATA_WIDTH-1:0]   load_val;
  logic                    unused_addr_bits;

  // Bytes above the memory window are dropped, so addresses wrap.
  assign unused_addr_bits = ^addr_i[31:WORDS+2];

`ifdef SUBWORD_EN
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lane_q, lane_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    byte_sel = mem_data_i[7:0];
    merged   = mem_data_i;
    case (lane_q)
      2'd0: begin byte_sel = mem_data_i[7:0];   merged[7:0]   = wdata_q[7:0]; end
      2'd1: begin byte_sel = mem_data_i[15:8];  merged[15:8]  = wdata_q[7:0]; end
      2'd2: begin byte_sel = mem_data_i[23:16]; merged[23:16] = wdata_q[7:0]; end
      default: begin byte_sel = mem_data_i[31:24]; merged[31:24] = wdata_q[7:0]; end
    endcase
    half_sel = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    if (funct3_q == F3_H) begin
      merged = mem_data_i;
      if (lane_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  always_comb begin
    case (funct3_q)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_val = {24'd0, byte_sel};
      F3_HU:   load_val = {16'd0, half_sel};
      default: load_val = mem_data_i;
    endcase
  end

  always_comb begin
    case (funct3_i)
      F3_W:          req_err = (addr_i[1:0] != 2'b00);
      F3_B:          req_err = 1'b0;
      F3_H:          req_err = addr_i[0];
      F3_BU:         req_err = we_i;
      F3_HU:         req_err = we_i | addr_i[0];
      default:       req_err = 1'b1;
    endcase
  end
`else
  assign load_val = mem_data_i;
  assign req_err  = (funct3_i != F3_W) || (addr_i[1:0] != 2'b00);
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wr_n_d = 1'b1;
    mem_rd_n_d = 1'b1;
`ifdef SUBWORD_EN
    we_d       = we_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
`ifdef SUBWORD_EN
          we_d     = we_i;
          funct3_d = funct3_i;
          lane_d   = addr_i[1:0];
          wdata_d  = wdata_i;
`endif
          err_d    = req_err;
          if (req_err) begin
            state_d = DONE;
          end else begin
            mem_addr_d = addr_i[WORDS+1:2];
            if (we_i && funct3_i == F3_W) begin
              mem_data_d = wdata_i;
              mem_wr_n_d = 1'b0;
              state_d    = WR;
            end else begin
              mem_rd_n_d = 1'b0;
              state_d    = RD;
            end
          end
        end
      end
      RD: begin
`ifdef SUBWORD_EN
        if (we_q) begin
          mem_data_d = merged;
          mem_wr_n_d = 1'b0;
          state_d    = WR;
        end else begin
          rdata_d = load_val;
          state_d = DONE;
        end
`else
        rdata_d = load_val;
        state_d = DONE;
`endif
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Reset clears the strobes asynchronously so an interrupted RMW never writes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wr_n_q <= 1'b1;
      mem_rd_n_q <= 1'b1;
`ifdef SUBWORD_EN
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wr_n_q <= mem_wr_n_d;
      mem_rd_n_q <= mem_rd_n_d;
`ifdef SUBWORD_EN
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
`endif
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == DONE) && err_q;
  assign rdata_o    = rdata_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_wr_no  = mem_wr_n_q;
  assign mem_rd_no  = mem_rd_n_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a negedge-sampling 1024x32 memory model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        ready_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_wr_no, mem_rd_no;
  logic [31:0] mem_data_i = '0;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = '0;

  mem_access_unit #(.WORDS(10), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .req_i(req_i), .we_i(we_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_wr_no(mem_wr_no), .mem_rd_no(mem_rd_no), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!mem_wr_no) mem[mem_addr_o] <= mem_data_o;
    if (!mem_rd_no) mem_data_i <= mem[mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ready"},  {31'd0, ready_o},   32'd1);
    check({tag, ".done"},   {31'd0, done_o},    32'd0);
    check({tag, ".err"},    {31'd0, err_o},     32'd0);
    check({tag, ".rdata"},  rdata_o,            32'd0);
    check({tag, ".maddr"},  {22'd0, mem_addr_o}, 32'd0);
    check({tag, ".mdata"},  mem_data_o,         32'd0);
    check({tag, ".wr_n"},   {31'd0, mem_wr_no}, 32'd1);
    check({tag, ".rd_n"},   {31'd0, mem_rd_no}, 32'd1);
  endtask

  // Issue one request, then scramble inputs to prove they were latched.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err,
                        input int exp_rd, input int exp_wr);
    int lat, rd_cnt, wr_cnt, both;
    logic err_seen;
    lat = -1; rd_cnt = 0; wr_cnt = 0; both = 0; err_seen = 1'b0;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, ready_o}, 32'd1);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = ~we; funct3_i = 3'b111; addr_i = 32'hFFFF_FFFF; wdata_i = 32'h0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (!mem_rd_no) rd_cnt++;
      if (!mem_wr_no) wr_cnt++;
      if (!mem_rd_no && !mem_wr_no) both++;
      if (done_o) begin
        lat = n;
        err_seen = err_o;
        break;
      end
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".err"}, {31'd0, err_seen}, {31'd0, exp_err});
    check({tag, ".rd_cycles"}, rd_cnt, exp_rd);
    check({tag, ".wr_cycles"}, wr_cnt, exp_wr);
    check({tag, ".both_low"}, both, 0);
    check({tag, ".rdata"}, rdata_o, exp_rdata);
    $display("op %s we=%0d f3=%b addr=%h wdata=%h lat=%0d err=%0d rdata=%h",
             tag, we, f3, addr, wd, lat, err_seen, rdata_o);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10] = 32'h55AA3312;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset_ni = 1'b1;

`ifdef SUBWORD_EN
    exp_rdata = 32'h00000055; run_op("lb_2B",  1'b0, 3'b000, 32'h2B, 32'h0, 2, 1'b0, 1, 0);
    exp_rdata = 32'hFFFFFFAA; run_op("lb_2A",  1'b0, 3'b000, 32'h2A, 32'h0, 2, 1'b0, 1, 0);
    exp_rdata = 32'h000000AA; run_op("lbu_2A", 1'b0, 3'b100, 32'h2A, 32'h0, 2, 1'b0, 1, 0);
    exp_rdata = 32'h00003312; run_op("lhu_28", 1'b0, 3'b101, 32'h28, 32'h0, 2, 1'b0, 1, 0);
    exp_rdata = 32'h000055AA; run_op("lh_2A",  1'b0, 3'b001, 32'h2A, 32'h0, 2, 1'b0, 1, 0);
    run_op("sb_29", 1'b1, 3'b000, 32'h29, 32'h123456EE, 3, 1'b0, 1, 1);
    check("sb_29.mem", mem[10], 32'h55AAEE12);
    exp_rdata = 32'h55AAEE12; run_op("lw_28", 1'b0, 3'b010, 32'h28, 32'h0, 2, 1'b0, 1, 0);
    exp_rdata = 32'hFFFFEE12; run_op("lh_28", 1'b0, 3'b001, 32'h28, 32'h0, 2, 1'b0, 1, 0);
    run_op("sh_2A", 1'b1, 3'b001, 32'h2A, 32'h0000BEEF, 3, 1'b0, 1, 1);
    check("sh_2A.mem", mem[10], 32'hBEEFEE12);
    run_op("sw_3FFC", 1'b1, 3'b010, 32'h3FFC, 32'h00000050, 2, 1'b0, 0, 1);
    check("sw_3FFC.mem", mem[1023], 32'h00000050);
    run_op("err_lw_2A", 1'b0, 3'b010, 32'h2A, 32'h0, 1, 1'b1, 0, 0);
    run_op("err_lh_29", 1'b0, 3'b001, 32'h29, 32'h0, 1, 1'b1, 0, 0);
    run_op("err_f3_011", 1'b0, 3'b011, 32'h28, 32'h0, 1, 1'b1, 0, 0);
    run_op("err_sh_2B", 1'b1, 3'b001, 32'h2B, 32'h0, 1, 1'b1, 0, 0);
    check("err.mem", mem[10], 32'hBEEFEE12);
    exp_rdata = 32'hBEEFEE12; run_op("lw_wrap_1028", 1'b0, 3'b010, 32'h1028, 32'h0, 2, 1'b0, 1, 0);
`else
    run_op("err_lb_2B", 1'b0, 3'b000, 32'h2B, 32'h0, 1, 1'b1, 0, 0);
    exp_rdata = 32'h55AA3312; run_op("lw_28", 1'b0, 3'b010, 32'h28, 32'h0, 2, 1'b0, 1, 0);
    run_op("err_sb_29", 1'b1, 3'b000, 32'h29, 32'h123456EE, 1, 1'b1, 0, 0);
    check("err_sb_29.mem", mem[10], 32'h55AA3312);
    run_op("sw_3FFC", 1'b1, 3'b010, 32'h3FFC, 32'h00000050, 2, 1'b0, 0, 1);
    check("sw_3FFC.mem", mem[1023], 32'h00000050);
    exp_rdata = 32'h00000050; run_op("lw_3FFC", 1'b0, 3'b010, 32'h3FFC, 32'h0, 2, 1'b0, 1, 0);
    run_op("err_lw_2A", 1'b0, 3'b010, 32'h2A, 32'h0, 1, 1'b1, 0, 0);
    run_op("err_f3_011", 1'b0, 3'b011, 32'h28, 32'h0, 1, 1'b1, 0, 0);
    run_op("err_sw_2A", 1'b1, 3'b010, 32'h2A, 32'h0, 1, 1'b1, 0, 0);
    exp_rdata = 32'h55AA3312; run_op("lw_wrap_1028", 1'b0, 3'b010, 32'h1028, 32'h0, 2, 1'b0, 1, 0);
`endif

    // Reset during the write cycle of a store: no write must reach memory.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h28; wdata_i = 32'h00000077;
`ifdef SUBWORD_EN
    funct3_i = 3'b000;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(posedge clk);
`else
    funct3_i = 3'b010;
    @(posedge clk);
`endif
    #1 req_i = 1'b0;
    check("rst_mid.wr_active", {31'd0, mem_wr_no}, 32'd0);
    reset_ni = 1'b0;
    #1;
    check("rst_mid.wr_n", {31'd0, mem_wr_no}, 32'd1);
    check("rst_mid.rd_n", {31'd0, mem_rd_no}, 32'd1);
    @(negedge clk);
    @(negedge clk);
`ifdef SUBWORD_EN
    check("rst_mid.mem", mem[10], 32'hBEEFEE12);
`else
    check("rst_mid.mem", mem[10], 32'h55AA3312);
`endif
    reset_ni = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");
    $display("op rst_mid done mem10=%h", mem[10]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
